ram_responder: RTL
==================

Name: ram_responder

Overview:
- Memory-side endpoint of the cache-to-RAM word protocol. Answers RAMSchreiben/RAMLesen strobes from the cache with RAMDatenGeschrieben/RAMDatenGelesen acknowledges.
- Backed by an internal word array with a fixed, parameterised response latency.
- Sits below the cache. It stands in for main memory in simulation and provides on-chip RAM on FPGA.

Parameters:
- ADDRBITS, 14: word-address bits used; array depth 2**ADDRBITS words of 32 bits.
- LATENCY, 2: cycles from strobe cycle to acknowledge cycle; legal range 1..15.
- REFRESH_INTERVAL, 64: cycles between refresh requests (used only with RAM_REFRESH_EN).
- REFRESH_CYCLES, 4: length of one refresh stall in cycles (used only with RAM_REFRESH_EN).

Ports:
- Clock  input  1  clock.
- Reset  input  1  reset.
- RAMSchreiben  input  1  one-cycle write strobe from initiator.
- RAMLesen  input  1  one-cycle read strobe from initiator.
- RAMAdresse  input  32  word address; only bits [ADDRBITS-1:0] used, upper bits ignored (aliasing).
- RAMSchreibDaten  input  32  write data, valid in strobe cycle.
- RAMLesDaten  output  32  read data, valid in the RAMDatenGelesen cycle.
- RAMDatenGeschrieben  output  1  one-cycle write acknowledge.
- RAMDatenGelesen  output  1  one-cycle read acknowledge.

Behaviour:
- Reset Reset, synchronous, active-high; clock Clock.
- Reset effects: all outputs 0, FSM to IDLE, latency counter 0, pending-request latch cleared.
  - Array contents are NOT cleared.
  - Reset mid-transaction aborts it: no acknowledge is issued, and an unacknowledged write is not committed.
- States: IDLE, WAIT, ACK, plus REFRESH when the feature is enabled.
- IDLE: a strobe sampled in cycle T latches address, write data and direction, then goes to WAIT with counter = LATENCY-1.
  - If LATENCY==1, go directly to ACK.
- WAIT: the counter decrements each cycle. Leave WAIT when counter==1, so ACK occupies cycle T+LATENCY.
- ACK, lasts exactly one cycle, then IDLE:
  - Read: RAMDatenGelesen=1 and RAMLesDaten=array[latched addr]. The data register is loaded on the edge entering ACK and holds its value until the next read ACK.
  - Write: RAMDatenGeschrieben=1. The array is written with latched data on the edge ending the ACK cycle.
- Exactly one acknowledge per accepted strobe; acknowledges are never asserted together.
- Strobes arriving in WAIT or ACK are ignored (protocol violation). A new strobe in the cycle immediately after ACK is accepted normally.
- RAMSchreiben and RAMLesen both high in one cycle: treated as a write; the read is dropped.
- Inputs are sampled only in the strobe cycle. Later changes to RAMAdresse or RAMSchreibDaten have no effect.
- Read-after-write to the same address, with the read strobe issued after the write ACK, returns the new data.

Optional Feature:
- RAM_REFRESH_EN defined: models DRAM refresh.
  - A free-running counter raises refresh-pending every REFRESH_INTERVAL cycles.
  - In IDLE with refresh pending and no strobe: enter REFRESH for REFRESH_CYCLES cycles, then clear pending. A strobe in the same cycle as pending wins, and the refresh is taken after the ACK.
  - A strobe arriving during REFRESH is captured in a one-entry pending latch. On exit, go to WAIT, with LATENCY counted from the first cycle after REFRESH.
  - No acknowledge is ever issued during REFRESH.
- RAM_REFRESH_EN undefined: no REFRESH state, no refresh counter. Latency is always exactly LATENCY.

Test Plan:
- Reset, LATENCY=2: all outputs 0 for 3 cycles after reset release. Read strobe addr 0x5 in cycle 10 -> RAMDatenGelesen high only in cycle 12.
- Write 0xDEADBEEF to 0x10 (strobe cycle 20) -> RAMDatenGeschrieben high cycle 22 only. Read 0x10 strobe cycle 23 -> RAMLesDaten=0xDEADBEEF with ack in cycle 25.
- Aliasing, ADDRBITS=14: write 0x11111111 to 0x00004003, read 0x00000003 -> 0x11111111.
- Protocol abuse:
  - Read strobe during WAIT of a prior write -> ignored; only the write ack appears.
  - Simultaneous RAMSchreiben/RAMLesen with data 0xA5A5A5A5 to 0x7 -> write ack only; later read 0x7 returns 0xA5A5A5A5.
- Reset asserted in WAIT of a write of 0x12345678 to 0x20 -> no ack; subsequent read 0x20 returns the prior value.
- RAM_REFRESH_EN, REFRESH_INTERVAL=8, REFRESH_CYCLES=4, LATENCY=2: read strobe in the first REFRESH cycle -> ack 3+2=5 cycles later; never during REFRESH.

Source files
------------

// File: rtl/ram_responder_if.sv
// Cache-to-RAM word protocol: strobes, address and write data from the cache,
// read data and one-cycle acknowledges from memory.
interface ram_responder_if;
    logic        RAMSchreiben;
    logic        RAMLesen;
    logic [31:0] RAMAdresse;
    logic [31:0] RAMSchreibDaten;
    logic [31:0] RAMLesDaten;
    logic        RAMDatenGeschrieben;
    logic        RAMDatenGelesen;

    modport master (
        output RAMSchreiben, RAMLesen, RAMAdresse, RAMSchreibDaten,
        input  RAMLesDaten, RAMDatenGeschrieben, RAMDatenGelesen
    );

    modport slave (
        input  RAMSchreiben, RAMLesen, RAMAdresse, RAMSchreibDaten,
        output RAMLesDaten, RAMDatenGeschrieben, RAMDatenGelesen
    );
endinterface

// File: rtl/ram_responder.sv
// Memory-side endpoint of the cache-to-RAM protocol with a fixed response latency.
// Define RAM_REFRESH_EN to model periodic DRAM refresh stalls.
module ram_responder #(
    parameter int unsigned ADDRBITS         = 14,
    parameter int unsigned LATENCY          = 2,
    parameter int unsigned REFRESH_INTERVAL = 64,
    parameter int unsigned REFRESH_CYCLES   = 4
) (
    input logic            Clock,
    input logic            Reset,
    ram_responder_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDRBITS;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
`ifdef RAM_REFRESH_EN
        StAck,
        StRefresh
`else
        StAck
`endif
    } state_t;

    state_t              state_q;
    logic [3:0]          lat_cnt_q;
    logic [ADDRBITS-1:0] addr_q;
    logic [31:0]         wdata_q;
    logic                is_write_q;
    logic [31:0]         rdata_q;
    logic                ack_wr_q;
    logic                ack_rd_q;
    logic [31:0]         mem [Depth];

    logic                strobe;
    logic                strobe_wr;
    logic [ADDRBITS-1:0] in_addr;
    logic                unused_addr;

    // A simultaneous read and write strobe is a write.
    assign strobe      = bus.RAMSchreiben | bus.RAMLesen;
    assign strobe_wr   = bus.RAMSchreiben;
    assign in_addr     = bus.RAMAdresse[ADDRBITS-1:0];
    assign unused_addr = ^bus.RAMAdresse[31:ADDRBITS];

    assign bus.RAMLesDaten         = rdata_q;
    assign bus.RAMDatenGeschrieben = ack_wr_q;
    assign bus.RAMDatenGelesen     = ack_rd_q;

`ifdef RAM_REFRESH_EN
    localparam int unsigned RefW = $clog2(REFRESH_INTERVAL + 1);
    localparam int unsigned RcW  = $clog2(REFRESH_CYCLES + 1);

    logic [RefW-1:0]     ref_tick_q;
    logic                ref_pend_q;
    logic [RcW-1:0]      ref_cnt_q;
    logic                req_pend_q;
    logic                ref_tick;
    logic [ADDRBITS-1:0] ref_addr;
    logic                ref_wr;

    assign ref_tick = (ref_tick_q == RefW'(REFRESH_INTERVAL - 1));
    // Request to replay on refresh exit: the latched one, else one arriving now.
    assign ref_addr = req_pend_q ? addr_q : in_addr;
    assign ref_wr   = req_pend_q ? is_write_q : strobe_wr;
`endif

    // Write commits on the edge that ends the write acknowledge cycle.
    always_ff @(posedge Clock) begin
        if (!Reset && state_q == StAck && is_write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            lat_cnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            ack_wr_q   <= 1'b0;
            ack_rd_q   <= 1'b0;
`ifdef RAM_REFRESH_EN
            ref_tick_q <= '0;
            ref_pend_q <= 1'b0;
            ref_cnt_q  <= '0;
            req_pend_q <= 1'b0;
`endif
        end else begin
            ack_wr_q <= 1'b0;
            ack_rd_q <= 1'b0;
`ifdef RAM_REFRESH_EN
            if (ref_tick) begin
                ref_tick_q <= '0;
                ref_pend_q <= 1'b1;
            end else begin
                ref_tick_q <= ref_tick_q + RefW'(1);
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (strobe) begin
                        addr_q     <= in_addr;
                        wdata_q    <= bus.RAMSchreibDaten;
                        is_write_q <= strobe_wr;
                        if (LATENCY == 1) begin
                            state_q  <= StAck;
                            ack_wr_q <= strobe_wr;
                            ack_rd_q <= !strobe_wr;
                            if (!strobe_wr) rdata_q <= mem[in_addr];
                        end else begin
                            state_q   <= StWait;
                            lat_cnt_q <= 4'(LATENCY - 1);
                        end
                    end
`ifdef RAM_REFRESH_EN
                    else if (ref_pend_q) begin
                        state_q   <= StRefresh;
                        ref_cnt_q <= RcW'(REFRESH_CYCLES - 1);
                    end
`endif
                end
                StWait: begin
                    lat_cnt_q <= lat_cnt_q - 4'd1;
                    if (lat_cnt_q == 4'd1) begin
                        state_q  <= StAck;
                        ack_wr_q <= is_write_q;
                        ack_rd_q <= !is_write_q;
                        if (!is_write_q) rdata_q <= mem[addr_q];
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
`ifdef RAM_REFRESH_EN
                StRefresh: begin
                    if (strobe && !req_pend_q) begin
                        addr_q     <= in_addr;
                        wdata_q    <= bus.RAMSchreibDaten;
                        is_write_q <= strobe_wr;
                        req_pend_q <= 1'b1;
                    end
                    if (ref_cnt_q == '0) begin
                        // A tick landing on the exit cycle must not be lost.
                        ref_pend_q <= ref_tick;
                        req_pend_q <= 1'b0;
                        if (req_pend_q || strobe) begin
                            if (LATENCY == 1) begin
                                state_q  <= StAck;
                                ack_wr_q <= ref_wr;
                                ack_rd_q <= !ref_wr;
                                if (!ref_wr) rdata_q <= mem[ref_addr];
                            end else begin
                                state_q   <= StWait;
                                lat_cnt_q <= 4'(LATENCY - 1);
                            end
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        ref_cnt_q <= ref_cnt_q - RcW'(1);
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
